// File: rtl/uart_transmitter.sv
// uart_transmitter: byte-wide valid/ready in, 8N1 serial frame out.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_transmitter #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SerialOut
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Bits that follow the start bit: data, optional parity, stop.
    localparam int SHIFT_W = FRAME_BITS - 1;

    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   sym_cnt;
    logic [3:0]         bit_cnt;
    logic [SHIFT_W-1:0] shift;
    logic [SHIFT_W-1:0] frame;

    // Shift image of a new byte, LSB first, stop bit in the top slot.
`ifdef UART_TX_PARITY_EN
    assign frame = {1'b1, ^DataIn, DataIn};
`else
    assign frame = {1'b1, DataIn};
`endif

    assign DataInReady = (state == IDLE);

    // Frame sequencer: accept a byte, then hold each bit for one symbol.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            SerialOut <= 1'b1;
            sym_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (DataInValid) begin
                        shift     <= frame;
                        state     <= SEND;
                        sym_cnt   <= '0;
                        bit_cnt   <= '0;
                        SerialOut <= 1'b0;
                    end
                end
                SEND: begin
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state     <= IDLE;
                            SerialOut <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            SerialOut <= shift[0];
                            shift     <= {1'b1, shift[SHIFT_W-1:1]};
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: random and directed frames against a
// cycle-timeline reference model of the serial line.
module tb_uart_transmitter;

    localparam int CF = 100_000_000;
    localparam int BR = 10_000_000;
    localparam int S  = CF / BR;
`ifdef UART_TX_PARITY_EN
    localparam int N = 11;
`else
    localparam int N = 10;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SerialOut;

    uart_transmitter #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SerialOut  (SerialOut)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is a list of line levels, each lasting S
    // cycles, starting at the handshake edge.
    int cyc = 0;
    bit m_busy = 0;
    int m_e0 = 0;
    bit m_bits[N];

    function automatic void load_frame(input logic [7:0] b);
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        m_bits[9] = ^b;
`endif
        m_bits[N-1] = 1'b1;
    endfunction

    always @(posedge CLK) begin
        bit rdy_before;
        cyc++;
        rdy_before = !m_busy;
        if (reset) begin
            m_busy = 0;
        end else if (rdy_before && DataInValid) begin
            load_frame(DataIn);
            m_e0 = cyc;
            m_busy = 1;
        end else if (m_busy && cyc == m_e0 + N * S) begin
            m_busy = 0;
        end
    end

    // Per-cycle comparison away from the active edge.
    logic rdy_prev = 1'b1;
    int   fall_q[$];

    always @(negedge CLK) begin
        if (cyc > 0) begin
            check("ready", DataInReady, !m_busy);
            check("line", SerialOut,
                  m_busy ? m_bits[(cyc - m_e0) / S] : 1'b1);
            if (rdy_prev && !DataInReady) fall_q.push_back(cyc);
            rdy_prev = DataInReady;
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!DataInReady && k < 500) begin
            step();
            k++;
        end
        check("ready_wait", DataInReady, 1'b1);
    endtask

    // One frame with noise on the inputs while it is being sent.
    task automatic send(input logic [7:0] b);
        int cnt;
        wait_ready();
        DataIn = b;
        DataInValid = 1'b1;
        step();
        cnt = 0;
        while (!DataInReady && cnt < 2000) begin
            cnt++;
            DataInValid = 1'($urandom);
            DataIn = 8'($urandom);
            step();
        end
        DataInValid = 1'b0;
        check("busy_len", cnt, N * S);
    endtask

    initial begin
        int cnt;
        int n;
        // Reset held for three edges
        repeat (3) step();
        check("rst_line", SerialOut, 1'b1);
        check("rst_ready", DataInReady, 1'b1);
        reset = 1'b0;
        repeat (4) step();

        send(8'hA5);
        step();
        send(8'h01);
        step();

        // Back-to-back with DataIn churn during SEND
        DataIn = 8'h55;
        DataInValid = 1'b1;
        step();
        cnt = 0;
        while (!DataInReady && cnt < 2000) begin
            cnt++;
            DataIn = 8'($urandom);
            step();
        end
        check("b2b_len", cnt, N * S);
        DataIn = 8'h0F;
        step();
        DataInValid = 1'b0;
        n = fall_q.size();
        check("b2b_gap", (n >= 2) ? fall_q[n-1] - fall_q[n-2] : 0,
              N * S + 1);
        wait_ready();
        step();

        // Mid-frame reset
        DataIn = 8'hFF;
        DataInValid = 1'b1;
        step();
        DataInValid = 1'b0;
        repeat (34) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_line", SerialOut, 1'b1);
        check("mid_rst_ready", DataInReady, 1'b1);
        repeat (20) step();
        send(8'h00);

        // Reset and valid on the same edge
        reset = 1'b1;
        DataInValid = 1'b1;
        DataIn = 8'h3C;
        step();
        reset = 1'b0;
        DataInValid = 1'b0;
        check("rst_vld_line", SerialOut, 1'b1);
        check("rst_vld_ready", DataInReady, 1'b1);
        repeat (5) step();

        // Random bytes with random idle gaps
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 5)) step();
        end
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
